dispatch_demux: RTL and testbench

DISPATCH_DEMUX -- requirements
Module: dispatch_demux

---
 rtl/dispatch_demux_pkg.sv | 35 +++
 rtl/dispatch_demux.sv | 138 +++++++++++++
 tb/tb_dispatch_demux.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dispatch_demux_pkg.sv
// Shared definitions for the dispatch demux and its arbiter-side consumers:
// sizing, word class encodings, FSM state encoding and the class decode.
package dispatch_demux_pkg;

   localparam int FIFO_UNITS  = 4;
   localparam int WORD_SIZE   = 10;
   localparam int STALL_LIMIT = 16;
   localparam int STALL_CNT_W = 5;

   typedef enum logic [1:0] {
      CLASS0 = 2'd0,
      CLASS1 = 2'd1,
      CLASS2 = 2'd2,
      CLASS3 = 2'd3
   } word_class_t;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_LOADED  = 2'd1,
      ST_STALLED = 2'd2
   } disp_state_t;

   function automatic logic [FIFO_UNITS-1:0] class_onehot(input logic [1:0] cls);
      logic [FIFO_UNITS-1:0] oh;
      case (cls)
         CLASS0:  oh = 4'b0001;
         CLASS1:  oh = 4'b0010;
         CLASS2:  oh = 4'b0100;
         CLASS3:  oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/dispatch_demux.sv
// Class-based demultiplexer: one hold register feeding per-class FIFOs, with
// idle-word dropping, backpressure stalling and a sticky stall timeout.
module dispatch_demux #(
   parameter int FIFO_UNITS  = dispatch_demux_pkg::FIFO_UNITS,
   parameter int WORD_SIZE   = dispatch_demux_pkg::WORD_SIZE,
   parameter int STALL_LIMIT = dispatch_demux_pkg::STALL_LIMIT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [WORD_SIZE-1:0]  in_data,
   output logic                  in_ready,
   input  logic [FIFO_UNITS-1:0] out_almost_full,
   output logic [FIFO_UNITS-1:0] push,
   output logic [WORD_SIZE-1:0]  push_data,
   output logic [7:0]            idle_drop_count,
   output logic                  stall_timeout
);
   import dispatch_demux_pkg::*;

   disp_state_t              state;
   disp_state_t              state_next;
   logic [WORD_SIZE-1:0]     hold;
   logic [WORD_SIZE-1:0]     hold_next;
   logic [STALL_CNT_W-1:0]   stall_cnt;
   logic [STALL_CNT_W-1:0]   stall_cnt_next;
   logic [7:0]               idle_next;
   logic                     timeout_next;
   logic [FIFO_UNITS-1:0]    held_route;
   logic [FIFO_UNITS-1:0]    in_route;
   logic [FIFO_UNITS-1:0]    push_int;
   logic                     push_fire;
   logic                     ready_int;
   logic                     accept;
   logic                     in_idle;
   logic                     in_dest_af;
   logic                     held_af;
   logic                     stalling;

   // Routing, push strobe and handshake decode
   always_comb begin
      held_route = class_onehot(hold[WORD_SIZE-1 -: 2]);
      in_route   = class_onehot(in_data[WORD_SIZE-1 -: 2]);
      held_af    = |(held_route & out_almost_full);
      in_dest_af = |(in_route & out_almost_full);
      if (state != ST_EMPTY) begin
         push_int = held_route & ~out_almost_full;
      end else begin
         push_int = '0;
      end
      push_fire = |push_int;
      ready_int = (state == ST_EMPTY) || push_fire;
      accept    = in_valid && ready_int && reset;
      in_idle   = (in_data[WORD_SIZE-1 -: 2] == CLASS0) && (in_data[WORD_SIZE-3:0] == '0);
      stalling  = (state == ST_STALLED) && !push_fire;
   end

   // Next state and hold register; an idle word never replaces the held word
   always_comb begin
      state_next = state;
      hold_next  = hold;
      if (accept && !in_idle) begin
         hold_next = in_data;
         if (in_dest_af) begin
            state_next = ST_STALLED;
         end else begin
            state_next = ST_LOADED;
         end
      end else if (push_fire) begin
         state_next = ST_EMPTY;
      end else if (state != ST_EMPTY) begin
         if (held_af) begin
            state_next = ST_STALLED;
         end else begin
            state_next = ST_LOADED;
         end
      end else begin
         state_next = ST_EMPTY;
      end
   end

   // Stall counter, sticky timeout and saturating idle-drop counter
   always_comb begin
      stall_cnt_next = '0;
      timeout_next   = stall_timeout;
      idle_next      = idle_drop_count;
      if (stalling) begin
         if (stall_cnt == {STALL_CNT_W{1'b1}}) begin
            stall_cnt_next = stall_cnt;
         end else begin
            stall_cnt_next = stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
         end
         if (int'(stall_cnt_next) >= STALL_LIMIT) begin
            timeout_next = 1'b1;
         end else begin
            timeout_next = stall_timeout;
         end
      end else begin
         stall_cnt_next = '0;
      end
      if (accept && in_idle && (idle_drop_count != 8'd255)) begin
         idle_next = idle_drop_count + 8'd1;
      end else begin
         idle_next = idle_drop_count;
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state           <= ST_EMPTY;
         hold            <= '0;
         stall_cnt       <= '0;
         idle_drop_count <= 8'd0;
         stall_timeout   <= 1'b0;
      end else begin
         state           <= state_next;
         hold            <= hold_next;
         stall_cnt       <= stall_cnt_next;
         idle_drop_count <= idle_next;
         stall_timeout   <= timeout_next;
      end
   end

   // Handshake outputs are forced quiet while reset is held low
   always_comb begin
      if (reset) begin
         in_ready  = ready_int;
         push      = push_int;
         push_data = hold;
      end else begin
         in_ready  = 1'b0;
         push      = '0;
         push_data = '0;
      end
   end

endmodule

// File: tb/tb_dispatch_demux.sv
// Directed bench for dispatch_demux with hand-computed expectations.
module tb_dispatch_demux;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [9:0] in_data;
   logic       in_ready;
   logic [3:0] out_almost_full;
   logic [3:0] push;
   logic [9:0] push_data;
   logic [7:0] idle_drop_count;
   logic       stall_timeout;

   int n_checks = 0;
   int n_pass   = 0;

   dispatch_demux dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_data         (in_data),
      .in_ready        (in_ready),
      .out_almost_full (out_almost_full),
      .push            (push),
      .push_data       (push_data),
      .idle_drop_count (idle_drop_count),
      .stall_timeout   (stall_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [9:0] words [4];

   initial begin
      words[0] = 10'h001;
      words[1] = 10'h102;
      words[2] = 10'h203;
      words[3] = 10'h304;

      reset = 1'b0; in_valid = 1'b1; in_data = 10'h155; out_almost_full = 4'b0000;
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_push", push, 0);
      check("rst_push_data", push_data, 0);
      check("rst_idle_cnt", idle_drop_count, 0);
      check("rst_timeout", stall_timeout, 0);

      reset = 1'b1; in_valid = 1'b0; #1;
      check("empty_in_ready", in_ready, 1);
      check("empty_push", push, 0);

      // four classes back to back
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = words[i]; #1;
         check("b2b_ready_pre", in_ready, 1);
         tick();
         check("b2b_push", push, 32'(4'b0001 << i));
         check("b2b_data", push_data, words[i]);
         check("b2b_ready", in_ready, 1);
      end
      in_valid = 1'b0;
      tick();
      check("b2b_done_push", push, 0);
      check("b2b_done_ready", in_ready, 1);

      // idle words
      in_valid = 1'b1; in_data = 10'h000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_push", push, 0);
      end
      check("idle_cnt3", idle_drop_count, 3);
      repeat (252) tick();
      check("idle_cnt255", idle_drop_count, 255);
      repeat (45) tick();
      check("idle_cnt_sat", idle_drop_count, 255);
      in_valid = 1'b0;

      // idle word accepted alongside a push leaves EMPTY
      in_valid = 1'b1; in_data = 10'h304;
      tick();
      in_data = 10'h000; #1;
      check("idlepush_push", push, 4'b1000);
      tick();
      in_valid = 1'b0; #1;
      check("idlepush_after_push", push, 0);
      check("idlepush_after_ready", in_ready, 1);

      // stall on FIFO1, unrelated backpressure on FIFO3, next word waits
      out_almost_full = 4'b0010; in_valid = 1'b1; in_data = 10'h155;
      tick();
      in_data = 10'h203; out_almost_full = 4'b1010;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_push", push, 0);
         check("stall_ready", in_ready, 0);
         tick();
      end
      out_almost_full = 4'b0000; #1;
      check("release_push", push, 4'b0010);
      check("release_data", push_data, 10'h155);
      check("release_ready", in_ready, 1);
      tick();
      in_valid = 1'b0; #1;
      check("order_push", push, 4'b0100);
      check("order_data", push_data, 10'h203);
      tick();
      check("order_done_push", push, 0);
      check("short_stall_timeout", stall_timeout, 0);

      // backpressure on a different FIFO does not stall the held word
      out_almost_full = 4'b0001; in_valid = 1'b1; in_data = 10'h3FF;
      tick();
      in_valid = 1'b0; #1;
      check("other_af_push", push, 4'b1000);
      check("other_af_data", push_data, 10'h3FF);
      check("other_af_ready", in_ready, 1);
      tick();
      out_almost_full = 4'b0000; #1;
      check("other_af_done", push, 0);

      // stall timeout after exactly STALL_LIMIT stalled cycles
      out_almost_full = 4'b0100; in_valid = 1'b1; in_data = 10'h2AA;
      tick();
      in_valid = 1'b0;
      repeat (15) tick();
      check("timeout_pre", stall_timeout, 0);
      tick();
      check("timeout_set", stall_timeout, 1);
      out_almost_full = 4'b0000; #1;
      check("timeout_release_push", push, 4'b0100);
      check("timeout_release_data", push_data, 10'h2AA);
      tick();
      check("timeout_sticky", stall_timeout, 1);
      check("timeout_done_push", push, 0);

      // reset during a stall discards the held word
      out_almost_full = 4'b0010; in_valid = 1'b1; in_data = 10'h1AB;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check("midrst_stall_push", push, 0);
      check("midrst_stall_ready", in_ready, 0);
      reset = 1'b0; #1;
      check("midrst_ready", in_ready, 0);
      check("midrst_push", push, 0);
      check("midrst_data", push_data, 0);
      tick();
      out_almost_full = 4'b0000; #1;
      check("midrst_push_free", push, 0);
      check("midrst_timeout", stall_timeout, 0);
      check("midrst_idle_cnt", idle_drop_count, 0);
      reset = 1'b1; #1;
      check("postrst_ready", in_ready, 1);
      check("postrst_push", push, 0);
      tick();
      check("postrst_push_next", push, 0);
      check("postrst_data", push_data, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
